// File: rtl/conv_mac_acc.sv
// conv_mac_acc: 4-stage convolution window MAC with multi-window accumulation, bias, ReLU and saturation.
// Ports: clk/rst (sync, active-high); in_valid/in_first/in_last frame window beats;
// ifmap_chunk/weight carry TAPS signed DATA_W values with tap 0 at the MSBs; bias/relu_en are
// sampled with the last beat; out_valid pulses with mac_output/sat_flag; err pulses on protocol error.
module conv_mac_acc #(
   parameter int DATA_W    = 16,
   parameter int KSIZE     = 3,
   parameter int FRAC_BITS = 14,
   parameter int OUT_W     = 18,
   parameter int MAX_CH    = 64
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  logic                            in_first,
   input  logic                            in_last,
   input  logic [KSIZE*KSIZE*DATA_W-1:0]   ifmap_chunk,
   input  logic [KSIZE*KSIZE*DATA_W-1:0]   weight,
   input  logic [OUT_W-1:0]                bias,
   input  logic                            relu_en,
   output logic                            out_valid,
   output logic [OUT_W-1:0]                mac_output,
   output logic                            sat_flag,
   output logic                            err
);
   localparam int TAPS   = KSIZE * KSIZE;
   localparam int PROD_W = 2 * DATA_W;
   localparam int ACC_W  = 2 * DATA_W + $clog2(TAPS) + $clog2(MAX_CH);
   localparam logic signed [OUT_W-1:0] MAX_O = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] MIN_O = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic signed [ACC_W:0]   MAX_V = (ACC_W+1)'(MAX_O);
   localparam logic signed [ACC_W:0]   MIN_V = (ACC_W+1)'(MIN_O);

   typedef enum logic {IDLE, ACCUM} state_t;

   // S1: products
   logic signed [PROD_W-1:0] prod_d [TAPS];
   logic signed [PROD_W-1:0] prod_q [TAPS];
   logic                     v1_q, f1_q, l1_q, relu1_q;
   logic [OUT_W-1:0]         bias1_q;
   // S2: row sums
   logic signed [ACC_W-1:0]  rs_d [KSIZE];
   logic signed [ACC_W-1:0]  rs_q [KSIZE];
   logic                     v2_q, f2_q, l2_q, relu2_q;
   logic [OUT_W-1:0]         bias2_q;
   // S3: accumulator
   state_t                   state_d, state_q;
   logic signed [ACC_W-1:0]  wsum, acc_d, acc_q;
   logic                     err_d, err_q, emit_d, emit_q, relu3_q;
   logic [OUT_W-1:0]         bias3_q;
   // S4: output
   logic signed [ACC_W-1:0]  shifted;
   logic signed [ACC_W:0]    res, rl;
   logic                     hi, lo;
   logic                     out_valid_d, out_valid_q, sat_d, sat_q;
   logic [OUT_W-1:0]         mac_d, mac_q;

   always_comb begin
      for (int t = 0; t < TAPS; t++)
         prod_d[t] = PROD_W'($signed(ifmap_chunk[(TAPS-1-t)*DATA_W +: DATA_W]))
                   * PROD_W'($signed(weight[(TAPS-1-t)*DATA_W +: DATA_W]));
   end

   always_comb begin
      wsum = '0;
      for (int r = 0; r < KSIZE; r++) begin
         rs_d[r] = '0;
         for (int c = 0; c < KSIZE; c++)
            rs_d[r] = rs_d[r] + ACC_W'(prod_q[r*KSIZE+c]);
         wsum = wsum + rs_q[r];
      end
   end

   // A beat without in_first in IDLE, or with in_first in ACCUM, is a protocol error;
   // either way the accumulation restarts from this window.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      err_d   = 1'b0;
      emit_d  = v2_q & l2_q;
      if (v2_q) begin
         err_d   = (state_q == ACCUM) ? f2_q : ~f2_q;
         acc_d   = (state_q == IDLE || f2_q) ? wsum : acc_q + wsum;
         state_d = l2_q ? IDLE : ACCUM;
      end
   end

   // ReLU is applied before saturation so a ReLU-zeroed result never reports sat_flag.
   always_comb begin
      shifted     = acc_q >>> FRAC_BITS;
      res         = (ACC_W+1)'(shifted) + (ACC_W+1)'($signed(bias3_q));
      rl          = (relu3_q && res < 0) ? '0 : res;
      hi          = rl > MAX_V;
      lo          = rl < MIN_V;
      out_valid_d = emit_q;
      mac_d       = emit_q ? (hi ? MAX_O : lo ? MIN_O : rl[OUT_W-1:0]) : mac_q;
      sat_d       = emit_q ? (hi | lo) : sat_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q      <= '{default: '0};
         v1_q        <= 1'b0;
         f1_q        <= 1'b0;
         l1_q        <= 1'b0;
         relu1_q     <= 1'b0;
         bias1_q     <= '0;
         rs_q        <= '{default: '0};
         v2_q        <= 1'b0;
         f2_q        <= 1'b0;
         l2_q        <= 1'b0;
         relu2_q     <= 1'b0;
         bias2_q     <= '0;
         state_q     <= IDLE;
         acc_q       <= '0;
         err_q       <= 1'b0;
         emit_q      <= 1'b0;
         relu3_q     <= 1'b0;
         bias3_q     <= '0;
         out_valid_q <= 1'b0;
         mac_q       <= '0;
         sat_q       <= 1'b0;
      end else begin
         prod_q      <= prod_d;
         v1_q        <= in_valid;
         f1_q        <= in_first;
         l1_q        <= in_last;
         relu1_q     <= relu_en;
         bias1_q     <= bias;
         rs_q        <= rs_d;
         v2_q        <= v1_q;
         f2_q        <= f1_q;
         l2_q        <= l1_q;
         relu2_q     <= relu1_q;
         bias2_q     <= bias1_q;
         state_q     <= state_d;
         acc_q       <= acc_d;
         err_q       <= err_d;
         emit_q      <= emit_d;
         relu3_q     <= relu2_q;
         bias3_q     <= bias2_q;
         out_valid_q <= out_valid_d;
         mac_q       <= mac_d;
         sat_q       <= sat_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign mac_output = mac_q;
   assign sat_flag   = sat_q;
   assign err        = err_q;
endmodule

// File: tb/tb_conv_mac_acc.sv
// tb_conv_mac_acc: directed checks of conv_mac_acc with hand-computed expected results.
module tb_conv_mac_acc;
   logic         clk, rst, in_valid, in_first, in_last, relu_en;
   logic [143:0] ifmap_chunk, weight;
   logic [17:0]  bias;
   logic         out_valid, sat_flag, err;
   logic [17:0]  mac_output;
   int           passed = 0, total = 0;

   conv_mac_acc dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
      .ifmap_chunk(ifmap_chunk), .weight(weight), .bias(bias), .relu_en(relu_en),
      .out_valid(out_valid), .mac_output(mac_output), .sat_flag(sat_flag), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic beat(input logic [15:0] p, input logic [15:0] w, input logic f, input logic l,
                       input logic [17:0] b, input logic r);
      in_valid    = 1'b1;
      ifmap_chunk = {9{p}};
      weight      = {9{w}};
      in_first    = f;
      in_last     = l;
      bias        = b;
      relu_en     = r;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   // Call right after driving the last beat (cycle N); checks N+1..N+5.
   task automatic expect_result(input string tag, input logic [17:0] exp, input logic esat,
                                input logic eerr);
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_ov_early"}, out_valid, 0);
         chk({tag, "_err"}, err, (i == 2) ? eerr : 1'b0);
         tick();
      end
      chk({tag, "_ov"}, out_valid, 1);
      chk({tag, "_mac"}, mac_output, exp);
      chk({tag, "_sat"}, sat_flag, esat);
      tick();
      chk({tag, "_ov_end"}, out_valid, 0);
      chk({tag, "_hold"}, mac_output, exp);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      ifmap_chunk = '0;
      weight = '0;
      bias = '0;
      relu_en = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_ov", out_valid, 0);
      chk("rst_mac", mac_output, 0);
      chk("rst_sat", sat_flag, 0);
      chk("rst_err", err, 0);

      beat(16'h4000, 16'h1000, 1, 1, 18'd0, 0);
      expect_result("single", 18'd36864, 0, 0);

      beat(16'h4000, 16'h4000, 1, 1, 18'd0, 0);
      expect_result("sat_pos", 18'd131071, 1, 0);

      beat(16'h4000, 16'h1000, 1, 0, 18'd0, 0);
      tick();
      beat(16'h4000, 16'h1000, 0, 0, 18'd0, 0);
      tick();
      beat(16'h4000, 16'h1000, 0, 1, -18'sd10592, 0);
      expect_result("three_win", 18'd100000, 0, 0);

      beat(16'h4000, 16'h1000, 1, 0, 18'd0, 0);
      tick();
      idle();
      tick();
      tick();
      beat(16'h4000, 16'h1000, 0, 0, 18'd0, 0);
      tick();
      idle();
      tick();
      tick();
      beat(16'h4000, 16'h1000, 0, 1, -18'sd10592, 0);
      expect_result("bubbles", 18'd100000, 0, 0);

      beat(16'h4000, 16'hF000, 1, 1, 18'd0, 0);
      expect_result("neg", 18'h37000, 0, 0);

      beat(16'h4000, 16'hF000, 1, 1, 18'd0, 1);
      expect_result("relu", 18'd0, 0, 0);

      beat(16'h4000, 16'hC000, 1, 1, 18'd0, 0);
      expect_result("sat_neg", 18'h20000, 1, 0);

      beat(16'h4000, 16'hC000, 1, 1, 18'd0, 1);
      expect_result("relu_sat_neg", 18'd0, 0, 0);

      beat(16'h4000, 16'h1000, 1, 1, 18'd131071, 0);
      expect_result("bias_sat", 18'd131071, 1, 0);

      beat(16'h4000, 16'h1000, 1, 0, 18'd0, 0);
      tick();
      beat(16'h4000, 16'h1000, 0, 0, 18'd0, 0);
      tick();
      beat(16'h4000, 16'h1000, 0, 1, 18'd0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      for (int i = 0; i < 6; i++) begin
         chk("rst_flight_ov", out_valid, 0);
         tick();
      end
      chk("rst_flight_err", err, 0);
      beat(16'h4000, 16'h1000, 1, 1, 18'd0, 0);
      expect_result("after_rst", 18'd36864, 0, 0);

      beat(16'h4000, 16'h1000, 0, 1, 18'd0, 0);
      expect_result("idle_no_first", 18'd36864, 0, 1);

      beat(16'h4000, 16'h1000, 1, 0, 18'd0, 0);
      tick();
      beat(16'h4000, 16'h1000, 0, 0, 18'd0, 0);
      tick();
      beat(16'h4000, 16'h1000, 1, 0, 18'd0, 0);
      tick();
      idle();
      tick();
      chk("restart_err_pre", err, 0);
      tick();
      chk("restart_err", err, 1);
      beat(16'h4000, 16'h1000, 0, 1, 18'd0, 0);
      expect_result("restart", 18'd73728, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
